// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control unit: FSM states, ALU and
// shifter commands, datapath mux selects, instruction fields and condition codes.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RESET    = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEMADR   = 4'd3,
        ST_MEMREAD  = 4'd4,
        ST_MEMWB    = 4'd5,
        ST_MEMWRITE = 4'd6,
        ST_EXECUTER = 4'd7,
        ST_EXECUTEI = 4'd8,
        ST_ALUWB    = 4'd9,
        ST_BRANCH   = 4'd10
    } state_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_EOR = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_RSB = 3'b011;
    localparam logic [2:0] ALU_ADD = 3'b100;
    localparam logic [2:0] ALU_ADC = 3'b101;
    localparam logic [2:0] ALU_SBC = 3'b110;
    localparam logic [2:0] ALU_ORR = 3'b111;

    localparam logic [2:0] SHIFT_NONE = 3'b111;

    localparam logic [1:0] ALUSRCA_PC     = 2'b00;
    localparam logic [1:0] ALUSRCA_RD1    = 2'b01;
    localparam logic [1:0] ALUSRCA_ALUOUT = 2'b10;

    localparam logic [1:0] ALUSRCB_RD2    = 2'b00;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b01;
    localparam logic [1:0] ALUSRCB_BRIMM  = 2'b10;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b11;

    localparam logic [1:0] RESULTSRC_ALUREG = 2'b00;
    localparam logic [1:0] RESULTSRC_DATA   = 2'b01;
    localparam logic [1:0] RESULTSRC_ALUOUT = 2'b10;

    localparam logic [1:0] REGSRC_DEFAULT = 2'b00;
    localparam logic [1:0] REGSRC_RD_AS_B = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_RSB = 4'b0011;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ADC = 4'b0101;
    localparam logic [3:0] CMD_SBC = 4'b0110;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    typedef struct packed {
        logic       supported;
        logic       is_cmp;
        logic [2:0] alu_op;
    } cmd_dec_t;

    // CMP reuses the SUB datapath; only the missing writeback distinguishes it.
    function automatic cmd_dec_t decode_cmd(input logic [3:0] cmd);
        cmd_dec_t d;
        d = '{supported: 1'b1, is_cmp: 1'b0, alu_op: ALU_AND};
        case (cmd)
            CMD_AND: d.alu_op = ALU_AND;
            CMD_EOR: d.alu_op = ALU_EOR;
            CMD_SUB: d.alu_op = ALU_SUB;
            CMD_RSB: d.alu_op = ALU_RSB;
            CMD_ADD: d.alu_op = ALU_ADD;
            CMD_ADC: d.alu_op = ALU_ADC;
            CMD_SBC: d.alu_op = ALU_SBC;
            CMD_ORR: d.alu_op = ALU_ORR;
            CMD_CMP: begin
                d.alu_op = ALU_SUB;
                d.is_cmp = 1'b1;
            end
            default: d.supported = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/multicycle_controller_cond_check.sv
// ARM condition-code evaluation: cond[3:0] against NZCV gives CondEx.
module cond_check
    import multicycle_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle CPU datapath: sequences fetch, decode,
// memory, data-processing and branch states and decodes every datapath strobe.
module multicycle_controller
    import multicycle_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] INSTRUCTION_OUT,
    input  logic [3:0]  FLAGS,
    output logic        A3Src,
    output logic        AdrSrc,
    output logic        FlagUpdate,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        WD3Src,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  RegSrc,
    output logic [2:0]  ALUop,
    output logic [2:0]  ShiftType,
    output logic [3:0]  state_o,
    output logic        instr_done
);

    state_t     state;
    logic [3:0] cond;
    logic [1:0] op;
    logic       imm_bit;
    logic [3:0] cmd;
    logic       s_bit;
    logic       l_mem;
    logic       l_br;
    logic [3:0] rd;
    logic [1:0] sh;
    logic [4:0] shamt;
    logic       cond_ex;
    logic       decode_exit;
    cmd_dec_t   dp;
    logic       unused_instr_bits;

    assign cond    = INSTRUCTION_OUT[31:28];
    assign op      = INSTRUCTION_OUT[27:26];
    assign imm_bit = INSTRUCTION_OUT[25];
    assign cmd     = INSTRUCTION_OUT[24:21];
    assign s_bit   = INSTRUCTION_OUT[20];
    assign l_mem   = INSTRUCTION_OUT[20];
    assign l_br    = INSTRUCTION_OUT[24];
    assign rd      = INSTRUCTION_OUT[15:12];
    assign shamt   = INSTRUCTION_OUT[11:7];
    assign sh      = INSTRUCTION_OUT[6:5];

    assign unused_instr_bits = ^{INSTRUCTION_OUT[19:16], INSTRUCTION_OUT[4:0]};

    assign dp = decode_cmd(cmd);

    cond_check u_cond_check (
        .cond    (cond),
        .flags   (FLAGS),
        .cond_ex (cond_ex)
    );

    // Failed condition, op 11 and unsupported data-processing commands all retire in DECODE.
    assign decode_exit = ~cond_ex || (op == 2'b11) || ((op == OP_DP) && ~dp.supported);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_RESET;
        end else begin
            case (state)
                ST_RESET:    state <= ST_FETCH;
                ST_FETCH:    state <= ST_DECODE;
                ST_DECODE: begin
                    if (decode_exit)
                        state <= ST_FETCH;
                    else if (op == OP_MEM)
                        state <= ST_MEMADR;
                    else if (op == OP_BR)
                        state <= ST_BRANCH;
                    else if (imm_bit)
                        state <= ST_EXECUTEI;
                    else
                        state <= ST_EXECUTER;
                end
                ST_MEMADR:   state <= l_mem ? ST_MEMREAD : ST_MEMWRITE;
                ST_MEMREAD:  state <= ST_MEMWB;
                ST_MEMWB:    state <= ST_FETCH;
                ST_MEMWRITE: state <= ST_FETCH;
                ST_EXECUTER,
                ST_EXECUTEI: state <= dp.is_cmp ? ST_FETCH : ST_ALUWB;
                ST_ALUWB:    state <= ST_FETCH;
                ST_BRANCH:   state <= ST_FETCH;
                default:     state <= ST_RESET;
            endcase
        end
    end

    assign state_o = state;

    always_comb begin
        A3Src      = 1'b0;
        AdrSrc     = 1'b0;
        FlagUpdate = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        WD3Src     = 1'b0;
        ALUSrcA    = '0;
        ALUSrcB    = '0;
        ResultSrc  = '0;
        RegSrc     = '0;
        ALUop      = '0;
        ShiftType  = SHIFT_NONE;
        instr_done = 1'b0;

        case (state)
            ST_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                AdrSrc    = 1'b0;
                ALUSrcA   = ALUSRCA_PC;
                ALUSrcB   = ALUSRCB_FOUR;
                ALUop     = ALU_ADD;
                ResultSrc = RESULTSRC_ALUOUT;
                RegSrc    = REGSRC_RD_AS_B;
            end
            ST_DECODE: begin
                ResultSrc  = RESULTSRC_ALUOUT;
                RegSrc     = {op == OP_MEM, op == OP_BR};
                instr_done = decode_exit;
            end
            ST_MEMADR: begin
                ALUSrcA = ALUSRCA_RD1;
                ALUSrcB = ALUSRCB_IMM;
                ALUop   = ALU_ADD;
                RegSrc  = REGSRC_RD_AS_B;
            end
            ST_MEMREAD: begin
                AdrSrc  = 1'b1;
                ALUSrcA = ALUSRCA_RD1;
                ALUSrcB = ALUSRCB_IMM;
                ALUop   = ALU_ADD;
                RegSrc  = REGSRC_RD_AS_B;
            end
            ST_MEMWB: begin
                AdrSrc     = 1'b1;
                ResultSrc  = RESULTSRC_DATA;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEMWRITE: begin
                AdrSrc     = 1'b1;
                ResultSrc  = RESULTSRC_ALUREG;
                MemWrite   = 1'b1;
                instr_done = 1'b1;
            end
            ST_EXECUTER: begin
                ALUSrcA    = ALUSRCA_RD1;
                ALUSrcB    = ALUSRCB_RD2;
                ALUop      = dp.alu_op;
                ShiftType  = (shamt != 5'd0) ? {1'b0, sh} : SHIFT_NONE;
                FlagUpdate = s_bit | dp.is_cmp;
                instr_done = dp.is_cmp;
            end
            ST_EXECUTEI: begin
                ALUSrcA    = ALUSRCA_RD1;
                ALUSrcB    = ALUSRCB_IMM;
                ALUop      = dp.alu_op;
                FlagUpdate = s_bit | dp.is_cmp;
                instr_done = dp.is_cmp;
            end
            ST_ALUWB: begin
                ALUSrcA    = ALUSRCA_ALUOUT;
                ResultSrc  = RESULTSRC_ALUREG;
                instr_done = 1'b1;
                // A write to R15 is a jump: steer it into the PC instead of the register file.
                if (rd == 4'd15)
                    PCWrite  = 1'b1;
                else
                    RegWrite = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcA    = ALUSRCA_PC;
                ALUSrcB    = ALUSRCB_BRIMM;
                ALUop      = ALU_ADD;
                ResultSrc  = RESULTSRC_ALUREG;
                PCWrite    = 1'b1;
                RegWrite   = l_br;
                A3Src      = l_br;
                WD3Src     = l_br;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed instructions push per-cycle
// expected state/strobe vectors, a negedge monitor pops and compares them.
module tb_multicycle_controller;

    logic        clock;
    logic        reset;
    logic [31:0] INSTRUCTION_OUT;
    logic [3:0]  FLAGS;
    logic        A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, RegSrc;
    logic [2:0]  ALUop, ShiftType;
    logic [3:0]  state_o;
    logic        instr_done;

    multicycle_controller dut (
        .clock           (clock),
        .reset           (reset),
        .INSTRUCTION_OUT (INSTRUCTION_OUT),
        .FLAGS           (FLAGS),
        .A3Src           (A3Src),
        .AdrSrc          (AdrSrc),
        .FlagUpdate      (FlagUpdate),
        .IRWrite         (IRWrite),
        .MemWrite        (MemWrite),
        .PCWrite         (PCWrite),
        .RegWrite        (RegWrite),
        .WD3Src          (WD3Src),
        .ALUSrcA         (ALUSrcA),
        .ALUSrcB         (ALUSrcB),
        .ResultSrc       (ResultSrc),
        .RegSrc          (RegSrc),
        .ALUop           (ALUop),
        .ShiftType       (ShiftType),
        .state_o         (state_o),
        .instr_done      (instr_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Vector layout: {state, A3Src,AdrSrc,FlagUpdate,IRWrite,MemWrite,PCWrite,RegWrite,WD3Src,
    //                 ALUSrcA, ALUSrcB, ResultSrc, RegSrc, ALUop, ShiftType, instr_done}
    typedef struct {
        string       nm;
        logic [26:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t ex(input string nm, input logic [3:0] st, input logic [7:0] strb,
                                input logic [1:0] asa, input logic [1:0] asb,
                                input logic [1:0] rs, input logic [1:0] rgs,
                                input logic [2:0] aop, input logic [2:0] sht, input logic done);
        exp_t e;
        e.nm = nm;
        e.v  = {st, strb, asa, asb, rs, rgs, aop, sht, done};
        return e;
    endfunction

    exp_t v_reset, v_fetch, v_dec_mem, v_dec_dp, v_dec_br, v_dec_skip, v_dec_skip_mem;
    exp_t v_madr, v_mread, v_mwb, v_mwrite;
    exp_t v_exr_add, v_exr_cmp, v_exr_lsl, v_exi_add, v_aluwb, v_aluwb_pc, v_branch;

    initial begin
        v_reset        = ex("reset",      4'd0,  8'b0000_0000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b111, 1'b0);
        v_fetch        = ex("fetch",      4'd1,  8'b0001_0100, 2'b00, 2'b11, 2'b10, 2'b10, 3'b100, 3'b111, 1'b0);
        v_dec_mem      = ex("dec_mem",    4'd2,  8'b0000_0000, 2'b00, 2'b00, 2'b10, 2'b10, 3'b000, 3'b111, 1'b0);
        v_dec_dp       = ex("dec_dp",     4'd2,  8'b0000_0000, 2'b00, 2'b00, 2'b10, 2'b00, 3'b000, 3'b111, 1'b0);
        v_dec_br       = ex("dec_br",     4'd2,  8'b0000_0000, 2'b00, 2'b00, 2'b10, 2'b01, 3'b000, 3'b111, 1'b0);
        v_dec_skip     = ex("dec_skip",   4'd2,  8'b0000_0000, 2'b00, 2'b00, 2'b10, 2'b00, 3'b000, 3'b111, 1'b1);
        v_dec_skip_mem = ex("dec_skipm",  4'd2,  8'b0000_0000, 2'b00, 2'b00, 2'b10, 2'b10, 3'b000, 3'b111, 1'b1);
        v_madr         = ex("memadr",     4'd3,  8'b0000_0000, 2'b01, 2'b01, 2'b00, 2'b10, 3'b100, 3'b111, 1'b0);
        v_mread        = ex("memread",    4'd4,  8'b0100_0000, 2'b01, 2'b01, 2'b00, 2'b10, 3'b100, 3'b111, 1'b0);
        v_mwb          = ex("memwb",      4'd5,  8'b0100_0010, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 3'b111, 1'b1);
        v_mwrite       = ex("memwrite",   4'd6,  8'b0100_1000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b111, 1'b1);
        v_exr_add      = ex("exr_add",    4'd7,  8'b0000_0000, 2'b01, 2'b00, 2'b00, 2'b00, 3'b100, 3'b111, 1'b0);
        v_exr_cmp      = ex("exr_cmp",    4'd7,  8'b0010_0000, 2'b01, 2'b00, 2'b00, 2'b00, 3'b010, 3'b111, 1'b1);
        v_exr_lsl      = ex("exr_lsl",    4'd7,  8'b0000_0000, 2'b01, 2'b00, 2'b00, 2'b00, 3'b100, 3'b000, 1'b0);
        v_exi_add      = ex("exi_add",    4'd8,  8'b0000_0000, 2'b01, 2'b01, 2'b00, 2'b00, 3'b100, 3'b111, 1'b0);
        v_aluwb        = ex("aluwb",      4'd9,  8'b0000_0010, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000, 3'b111, 1'b1);
        v_aluwb_pc     = ex("aluwb_pc",   4'd9,  8'b0000_0100, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000, 3'b111, 1'b1);
        v_branch       = ex("branch_bl",  4'd10, 8'b1000_0111, 2'b00, 2'b10, 2'b00, 2'b00, 3'b100, 3'b111, 1'b1);
    end

    always @(negedge clock) begin
        exp_t        e;
        logic [26:0] act;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {state_o, A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src,
                   ALUSrcA, ALUSrcB, ResultSrc, RegSrc, ALUop, ShiftType, instr_done};
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s @%0t: got %07h expected %07h", e.nm, $time, act, e.v);
            end
        end
    end

    task automatic step(input exp_t e);
        @(posedge clock);
        #1;
        sb.push_back(e);
    endtask

    // The IR only changes once FETCH has begun, after the previous instruction's last edge.
    task automatic load(input logic [31:0] ins, input logic [3:0] fl);
        step(v_fetch);
        INSTRUCTION_OUT = ins;
        FLAGS = fl;
    endtask

    initial begin
        reset = 1'b0;
        INSTRUCTION_OUT = '0;
        FLAGS = '0;

        step(v_reset);
        step(v_reset);
        reset = 1'b1;

        load(32'hE5911040, 4'b0000);
        step(v_dec_mem); step(v_madr); step(v_mread); step(v_mwb);

        load(32'hE0810002, 4'b0000);
        step(v_dec_dp); step(v_exr_add); step(v_aluwb);

        load(32'hE1510002, 4'b0000);
        step(v_dec_dp); step(v_exr_cmp);

        load(32'h00810002, 4'b0000);
        step(v_dec_skip);

        load(32'h00810002, 4'b0100);
        step(v_dec_dp); step(v_exr_add); step(v_aluwb);

        load(32'hEB000003, 4'b0000);
        step(v_dec_br); step(v_branch);

        load(32'hE5811040, 4'b0000);
        step(v_dec_mem); step(v_madr); step(v_mwrite);

        load(32'hE0810182, 4'b0000);
        step(v_dec_dp); step(v_exr_lsl); step(v_aluwb);

        load(32'hE2810005, 4'b0000);
        step(v_dec_dp); step(v_exi_add); step(v_aluwb);

        load(32'hE081F002, 4'b0000);
        step(v_dec_dp); step(v_exr_add); step(v_aluwb_pc);

        load(32'hE1A00001, 4'b0000);
        step(v_dec_skip);

        load(32'hEC000000, 4'b0000);
        step(v_dec_skip);

        load(32'h10810002, 4'b0100);
        step(v_dec_skip);

        load(32'hF0810002, 4'b1111);
        step(v_dec_skip);

        load(32'hF5911040, 4'b0000);
        step(v_dec_skip_mem);

        load(32'hA0810002, 4'b1001);
        step(v_dec_dp); step(v_exr_add); step(v_aluwb);

        load(32'hB0810002, 4'b1000);
        step(v_dec_dp); step(v_exr_add); step(v_aluwb);

        load(32'hE5911040, 4'b0000);
        step(v_dec_mem); step(v_madr); step(v_mread);
        reset = 1'b0;
        step(v_reset);
        reset = 1'b1;

        load(32'hE0810002, 4'b0000);
        step(v_dec_dp); step(v_exr_add); step(v_aluwb);

        repeat (3) @(negedge clock);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
